instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 front end. Owns the PC, issues one word fetch at a
// time to instruction memory, and hands each instruction plus its PC to
// decode. Branch/jump redirects replace the PC and kill any fetch that is
// already in flight. A watchdog retries a fetch whose response never arrives.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_req_valid/ready/addr   fetch request (valid/ready), word address
//   imem_rsp_valid/data         fetch response (valid-only, 1-cycle pulse)
//   id_valid/ready/instr/pc     instruction handoff to decode (valid/ready)
//   redirect_valid/pc           new PC from branch/jump resolution
//   misaligned                  pulse: redirect target not word aligned, ignored
//   fetch_timeout               pulse: response missing for RESP_LAT_MAX cycles
//   fetch_count                 number of decode handshakes, wraps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned RESP_LAT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned,
  output logic        fetch_timeout,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] WD_LAST = 32'(RESP_LAT_MAX - 1);

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] wd;
  logic        redir_ok;
  logic        redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Handshake outputs decode directly from the state register.
  assign imem_req_valid = (state == REQ);
  assign id_valid       = (state == HOLD);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      wd            <= '0;
      id_instr      <= '0;
      id_pc         <= RESET_PC;
      fetch_count   <= '0;
      misaligned    <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      misaligned    <= redir_bad;
      fetch_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (redir_ok) pc <= redirect_pc;
          state <= REQ;
        end
        REQ: begin
          if (redir_ok) pc <= redirect_pc;
          if (imem_req_ready) begin
            // A request accepted alongside a redirect carried the old pc.
            kill  <= redir_ok;
            wd    <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            wd   <= '0;
            kill <= 1'b0;
            if (redir_ok) begin
              pc    <= redirect_pc;
              state <= REQ;
            end else if (kill) begin
              // pc already holds the redirect target
              state <= REQ;
            end else begin
              id_instr <= imem_rsp_data;
              id_pc    <= pc;
              pc       <= pc + 32'd4;
              state    <= HOLD;
            end
          end else begin
            if (redir_ok) begin
              pc   <= redirect_pc;
              kill <= 1'b1;
            end
            // Timeout retries at the current pc; any pending kill is moot
            // because the stale response can no longer reach WAIT.
            if (wd == WD_LAST) begin
              fetch_timeout <= 1'b1;
              kill          <= 1'b0;
              wd            <= '0;
              state         <= REQ;
            end else begin
              wd <= wd + 32'd1;
            end
          end
        end
        HOLD: begin
          if (redir_ok) begin
            pc    <= redirect_pc;
            state <= REQ;
          end else if (id_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit. A second instance
// with RESET_PC=0xFFFFFFFC shares all inputs to cover PC wrap-around.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        a_req_valid, a_id_valid, a_misaligned, a_timeout;
  logic [31:0] a_req_addr, a_id_instr, a_id_pc, a_count;
  logic        b_req_valid, b_id_valid, b_misaligned, b_timeout;
  logic [31:0] b_req_addr, b_id_instr, b_id_pc, b_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .RESP_LAT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(a_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(a_id_valid), .id_ready(id_ready),
    .id_instr(a_id_instr), .id_pc(a_id_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misaligned(a_misaligned),
    .fetch_timeout(a_timeout), .fetch_count(a_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .RESP_LAT_MAX(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(b_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(b_id_valid), .id_ready(id_ready),
    .id_instr(b_id_instr), .id_pc(b_id_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misaligned(b_misaligned),
    .fetch_timeout(b_timeout), .fetch_count(b_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed stalled bench expected completion");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    check("rst_req_valid", 32'(a_req_valid), 32'd0);
    check("rst_addr", a_req_addr, 32'h0);
    check("rst_id_valid", 32'(a_id_valid), 32'd0);
    check("rst_id_pc", a_id_pc, 32'h0);
    check("rst_count", a_count, 32'd0);
    check("rst_misaligned", 32'(a_misaligned), 32'd0);
    check("rst_timeout", 32'(a_timeout), 32'd0);
    check("rst_wrap_addr", b_req_addr, 32'hFFFF_FFFC);
    check("rst_wrap_id_pc", b_id_pc, 32'hFFFF_FFFC);

    // First fetch: IDLE -> REQ one cycle after release.
    rst_n = 1'b1;
    step();
    check("first_req_valid", 32'(a_req_valid), 32'd1);
    check("first_req_addr", a_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_no_req", 32'(a_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("hold_id_valid", 32'(a_id_valid), 32'd1);
    check("hold_id_instr", a_id_instr, 32'h0050_0093);
    check("hold_id_pc", a_id_pc, 32'h0);
    check("wrap_id_pc", b_id_pc, 32'hFFFF_FFFC);

    // Decode stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", a_id_instr, 32'h0050_0093);
      check("stall_pc", a_id_pc, 32'h0);
      check("stall_no_req", 32'(a_req_valid), 32'd0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("accept_count", a_count, 32'd1);
    check("next_req_valid", 32'(a_req_valid), 32'd1);
    check("next_req_addr", a_req_addr, 32'h4);
    check("accept_id_valid", 32'(a_id_valid), 32'd0);
    check("wrap_next_addr", b_req_addr, 32'h0);
    check("wrap_count", b_count, 32'd1);

    // Redirect in WAIT; the stale response is discarded.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("redir_wait_no_req", 32'(a_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("stale_no_id_valid", 32'(a_id_valid), 32'd0);
    check("stale_id_instr", a_id_instr, 32'h0050_0093);
    check("redir_req_valid", 32'(a_req_valid), 32'd1);
    check("redir_req_addr", a_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0113;
    step();
    imem_rsp_valid = 1'b0;
    check("redir_id_instr", a_id_instr, 32'h00A0_0113);
    check("redir_id_pc", a_id_pc, 32'h100);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("redir_count", a_count, 32'd2);
    check("redir_next_addr", a_req_addr, 32'h104);

    // Misaligned redirect in REQ is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("mis_pulse", 32'(a_misaligned), 32'd1);
    check("mis_addr", a_req_addr, 32'h104);
    check("mis_req_valid", 32'(a_req_valid), 32'd1);
    step();
    check("mis_pulse_end", 32'(a_misaligned), 32'd0);
    check("mis_addr_hold", a_req_addr, 32'h104);

    // Aligned redirect in REQ without handshake.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("req_redir_addr", a_req_addr, 32'h200);
    check("req_redir_valid", 32'(a_req_valid), 32'd1);

    // Redirect in HOLD with coincident id_ready: no count.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    check("hold2_id_pc", a_id_pc, 32'h200);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    id_ready = 1'b0; redirect_valid = 1'b0;
    check("hold_redir_count", a_count, 32'd2);
    check("hold_redir_id_valid", 32'(a_id_valid), 32'd0);
    check("hold_redir_addr", a_req_addr, 32'h300);

    // Watchdog: no response after handshake.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      check("wd_quiet", 32'(a_timeout), 32'd0);
      check("wd_no_req", 32'(a_req_valid), 32'd0);
    end
    step();
    check("wd_pulse", 32'(a_timeout), 32'd1);
    check("wd_retry_valid", 32'(a_req_valid), 32'd1);
    check("wd_retry_addr", a_req_addr, 32'h300);
    step();
    check("wd_pulse_end", 32'(a_timeout), 32'd0);

    // Redirect coincident with request handshake kills that request.
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    check("kill_in_wait", 32'(a_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_AAAA;
    step();
    imem_rsp_valid = 1'b0;
    check("kill_no_id_valid", 32'(a_id_valid), 32'd0);
    check("kill_req_addr", a_req_addr, 32'h400);
    check("kill_req_valid", 32'(a_req_valid), 32'd1);

    // Reset mid-fetch; late response ignored.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_addr", a_req_addr, 32'h0);
    check("mid_rst_req_valid", 32'(a_req_valid), 32'd0);
    check("mid_rst_count", a_count, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_5555;
    step();
    imem_rsp_valid = 1'b0;
    check("late_rsp_req_valid", 32'(a_req_valid), 32'd1);
    check("late_rsp_id_valid", 32'(a_id_valid), 32'd0);
    check("late_rsp_id_instr", a_id_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
